// File: rtl/rv_pkg.sv
// Shared definitions for the RV fetch path.
//   XLEN_DEFAULT / ILEN_DEFAULT : default PC and instruction widths
//   fetch_state_e               : fetch FSM state encoding
//   NOP                         : instruction shown to decode when nothing is queued
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned ILEN_DEFAULT = 32;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clear        : empties the queue (pointers and count back to zero)
//   push, pop    : write tail / retire head; ignored when full / empty
//   push_data    : tail entry
//   head_data    : head entry (storage output, valid when !empty)
//   full, empty  : occupancy flags
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_data = mem_q[head_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + PW'(1);
      if (do_pop)  head_q <= head_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[tail_q] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage sitting between program_counter and decode.
// Issues one instruction-memory request at a time, queues returned
// instructions with their PC and hands them to decode over valid/ready.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   pc                  : current PC (word address) from program_counter
//   pc_enable           : advance/load strobe to program_counter
//   flush               : redirect; PC target arrives via program_counter
//   imem_req, imem_addr : one-cycle request strobe and word address
//   imem_rdata/rvalid   : returned instruction, variable latency >= 1
//   if_valid/pc/instr   : head of fetch queue to decode
//   id_ready            : decode accepts head
module fetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned ILEN   = ILEN_DEFAULT,
  parameter int unsigned QDEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_enable,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            imem_rvalid,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  input  logic            id_ready
);

  fetch_state_e    state_q, state_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic                 issue;
  logic                 q_push, q_pop, q_full, q_empty;
  logic [XLEN+ILEN-1:0] q_rdata;
  logic [XLEN-1:0]      head_pc;
  logic [ILEN-1:0]      head_instr;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (q_push),
    .pop       (q_pop),
    .push_data ({req_pc_q, imem_rdata}),
    .head_data (q_rdata),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign {head_pc, head_instr} = q_rdata;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      discard_q <= 1'b0;
      req_pc_q  <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      req_pc_q  <= req_pc_d;
    end
  end

  // Next state. A response arriving in WAIT always ends the transaction,
  // whether it is kept, dropped by a pending discard, or dropped by flush.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req_pc_d  = req_pc_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d  = StWait;
          req_pc_d = pc;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          state_d   = StIdle;
          discard_d = 1'b0;
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    issue     = !reset && (state_q == StIdle) && !q_full && !flush;
    imem_req  = issue;
    imem_addr = issue ? pc : '0;
    q_push    = !reset && (state_q == StWait) && imem_rvalid && !discard_q && !flush;
    pc_enable = !reset && (q_push || flush);
    // Flush clears the queue, so a same-cycle pop is cancelled.
    q_pop     = !q_empty && id_ready && !flush;
    if_valid  = !q_empty;
    if_pc     = q_empty ? '0 : head_pc;
    if_instr  = q_empty ? ILEN'(NOP) : head_instr;
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset, flush, id_ready, imem_rvalid;
  logic [31:0] pc, imem_rdata;
  logic        pc_enable, imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;

  fetch_stage #(.XLEN(32), .ILEN(32), .QDEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .pc_enable   (pc_enable),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .id_ready    (id_ready)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] NOP_I = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          pen;
    bit          valid;
    logic [31:0] ipc;
    logic [31:0] instr;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Program counter and memory models
  int          cyc = 0;
  int          lat = 1;
  int          mode = 0;
  logic [31:0] target = '0;
  bit          pend = 0, pkill = 0, cur_kill = 0;
  int          due = 0;
  logic [31:0] paddr = '0, dpc = '0;
  ent_t        exp_q[$];

  // Outputs sampled in the cycle just completed
  logic        s_req, s_pen, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (mode == 0) ? 32'h00A0_0093 : a + 32'h100;
  endfunction

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    ent_t e;
    #2;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_pen   = pc_enable;
    s_valid = if_valid;
    s_pc    = if_pc;
    s_instr = if_instr;
    if (!reset && s_valid && id_ready && !flush) begin
      if (exp_q.size() == 0) begin
        fail("sb_pop_unexpected", s_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", s_pc, e.pc);
        chk("sb_instr", s_instr, e.instr);
      end
    end
    if (reset || flush) begin
      exp_q.delete();
      if (pend) pkill = 1;
    end else if (imem_rvalid && !cur_kill) begin
      e.pc    = dpc;
      e.instr = imem_rdata;
      exp_q.push_back(e);
    end
    if (s_req && pend) fail("one_outstanding", s_addr, paddr);
    @(posedge clock);
    cyc++;
    #1;
    if (s_pen) pc = flush ? target : pc + 32'd1;
    if (s_req) begin
      pend  = 1;
      pkill = 0;
      due   = cyc - 1 + lat;
      paddr = s_addr;
    end
    if (pend && due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(paddr);
      dpc         = paddr;
      cur_kill    = pkill;
      pend        = 0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      cur_kill    = 0;
    end
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    reset = 1'b1;
    flush = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 10 && pend; i++) tick();
    pc    = start_pc;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   nreq, npen;
    logic [31:0] a0, a1;

    tbl[0] = '{1, 1, 0, 32'h0, 0, 0, 32'h0, NOP_I};
    tbl[1] = '{1, 1, 0, 32'h0, 0, 0, 32'h0, NOP_I};
    tbl[2] = '{0, 1, 1, 32'h0, 0, 0, 32'h0, NOP_I};
    tbl[3] = '{0, 1, 0, 32'h0, 1, 0, 32'h0, NOP_I};
    tbl[4] = '{0, 1, 1, 32'h1, 0, 1, 32'h0, 32'h00A0_0093};
    tbl[5] = '{0, 1, 0, 32'h0, 1, 0, 32'h0, NOP_I};

    reset = 1'b1; flush = 1'b0; id_ready = 1'b1; imem_rvalid = 1'b0;
    imem_rdata = '0; pc = '0; lat = 1; mode = 0;

    // Reset then first fetch with 1-cycle memory
    for (int i = 0; i < 6; i++) begin
      reset    = tbl[i].rst;
      id_ready = tbl[i].rdy;
      tick();
      chk($sformatf("t1_req[%0d]", i), 32'(s_req), 32'(tbl[i].req));
      chk($sformatf("t1_addr[%0d]", i), s_addr, tbl[i].addr);
      chk($sformatf("t1_pen[%0d]", i), 32'(s_pen), 32'(tbl[i].pen));
      chk($sformatf("t1_valid[%0d]", i), 32'(s_valid), 32'(tbl[i].valid));
      chk($sformatf("t1_ifpc[%0d]", i), s_pc, tbl[i].ipc);
      chk($sformatf("t1_instr[%0d]", i), s_instr, tbl[i].instr);
    end

    // Decode stalled: queue fills after two requests, PC holds
    mode = 1; id_ready = 1'b0; lat = 1;
    do_reset(32'h0);
    nreq = 0; npen = 0; a0 = 'x; a1 = 'x;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_req) begin
        if (nreq == 0) a0 = s_addr;
        if (nreq == 1) a1 = s_addr;
        nreq++;
      end
      if (s_pen) npen++;
    end
    chk("t2_nreq", 32'(nreq), 32'd2);
    chk("t2_npen", 32'(npen), 32'd2);
    chk("t2_addr0", a0, 32'h0);
    chk("t2_addr1", a1, 32'h1);
    chk("t2_full_valid", 32'(s_valid), 32'd1);
    chk("t2_full_noreq", 32'(s_req), 32'd0);
    id_ready = 1'b1;
    tick();
    chk("t2_drain_pc0", s_pc, 32'h0);
    chk("t2_drain_noreq", 32'(s_req), 32'd0);
    tick();
    chk("t2_drain_pc1", s_pc, 32'h1);
    chk("t2_drain_instr1", s_instr, 32'h101);
    chk("t2_resume_req", 32'(s_req), 32'd1);
    chk("t2_resume_addr", s_addr, 32'h2);

    // Flush one cycle after a request with 3-cycle memory
    lat = 3;
    do_reset(32'h5);
    tick();
    chk("t3_req", 32'(s_req), 32'd1);
    chk("t3_addr", s_addr, 32'h5);
    flush = 1'b1; target = 32'h40;
    tick();
    chk("t3_flush_pen", 32'(s_pen), 32'd1);
    chk("t3_flush_noreq", 32'(s_req), 32'd0);
    flush = 1'b0;
    tick();
    chk("t3_wait_pen", 32'(s_pen), 32'd0);
    chk("t3_wait_noreq", 32'(s_req), 32'd0);
    tick();
    chk("t3_drop_pen", 32'(s_pen), 32'd0);
    chk("t3_drop_valid", 32'(s_valid), 32'd0);
    tick();
    chk("t3_redir_req", 32'(s_req), 32'd1);
    chk("t3_redir_addr", s_addr, 32'h40);
    tick();
    tick();
    tick();
    chk("t3_push_pen", 32'(s_pen), 32'd1);
    tick();
    chk("t3_valid", 32'(s_valid), 32'd1);
    chk("t3_ifpc", s_pc, 32'h40);
    chk("t3_instr", s_instr, 32'h140);

    // Flush coincident with the response
    lat = 2;
    do_reset(32'h10);
    tick();
    chk("t4_req", 32'(s_req), 32'd1);
    tick();
    flush = 1'b1; target = 32'h80;
    tick();
    chk("t4_flush_pen", 32'(s_pen), 32'd1);
    chk("t4_flush_noreq", 32'(s_req), 32'd0);
    flush = 1'b0;
    tick();
    chk("t4_idle_req", 32'(s_req), 32'd1);
    chk("t4_idle_addr", s_addr, 32'h80);
    chk("t4_novalid", 32'(s_valid), 32'd0);
    tick();
    tick();
    chk("t4_push_pen", 32'(s_pen), 32'd1);
    tick();
    chk("t4_valid", 32'(s_valid), 32'd1);
    chk("t4_ifpc", s_pc, 32'h80);

    // Flush with a full queue and decode ready
    lat = 1; id_ready = 1'b0;
    do_reset(32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_full_valid", 32'(s_valid), 32'd1);
    flush = 1'b1; id_ready = 1'b1; target = 32'h200;
    tick();
    chk("t5_flush_pen", 32'(s_pen), 32'd1);
    chk("t5_flush_noreq", 32'(s_req), 32'd0);
    flush = 1'b0;
    tick();
    chk("t5_cleared_valid", 32'(s_valid), 32'd0);
    chk("t5_req", 32'(s_req), 32'd1);
    chk("t5_addr", s_addr, 32'h200);
    tick();
    tick();
    chk("t5_valid", 32'(s_valid), 32'd1);
    chk("t5_ifpc", s_pc, 32'h200);

    // Reset mid-WAIT with a stale response after release
    lat = 2; id_ready = 1'b1;
    do_reset(32'h7);
    tick();
    chk("t6_req", 32'(s_req), 32'd1);
    chk("t6_addr", s_addr, 32'h7);
    lat = 1;
    reset = 1'b1; pc = 32'h9;
    tick();
    chk("t6_rst_req", 32'(s_req), 32'd0);
    chk("t6_rst_valid", 32'(s_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("t6_stale_pen", 32'(s_pen), 32'd0);
    chk("t6_new_req", 32'(s_req), 32'd1);
    chk("t6_new_addr", s_addr, 32'h9);
    tick();
    chk("t6_no_stale_valid", 32'(s_valid), 32'd0);
    chk("t6_push_pen", 32'(s_pen), 32'd1);
    tick();
    chk("t6_valid", 32'(s_valid), 32'd1);
    chk("t6_ifpc", s_pc, 32'h9);
    chk("t6_instr", s_instr, 32'h109);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
